// File: rtl/uart_tx_arbiter.sv
//------------------------------------------------------------------------------
// Module   : uart_tx_arbiter
// Brief    : Round-robin scheduler sharing one UART TX serializer among N_REQ
//            byte sources; one frame per grant, abandoned after TIMEOUT cycles.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_arbiter #(
   parameter  int N_REQ   = 4,
   parameter  int TIMEOUT = 16,
   localparam int GW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                 baud_clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]     req_ready,
   output logic                 ser_en,
   output logic [7:0]           ser_data,
   input  logic                 ser_busy,
   input  logic                 ser_done,
   output logic [GW-1:0]        grant_id,
   output logic                 active,
   output logic                 timeout_err,
   output logic [15:0]          frame_cnt
);

   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_DONE = 2'd2,
      GAP       = 2'd3
   } state_t;

   state_t            r_state, w_state_nx;
   logic [GW-1:0]     r_rr_ptr, w_rr_nx;
   logic [TW-1:0]     r_timer, w_timer_nx;
   logic [N_REQ-1:0]  w_ready_nx;
   logic              w_ser_en_nx;
   logic [7:0]        w_ser_data_nx;
   logic [GW-1:0]     w_grant_nx;
   logic              w_active_nx;
   logic              w_timeout_nx;
   logic [15:0]       w_frame_cnt_nx;
   logic [GW-1:0]     w_win;
   logic [GW:0]       w_idx;
   logic [GW-1:0]     w_after_grant;
   logic              w_unused_busy;

   // Status only; the frame sequence is paced entirely by ser_done.
   assign w_unused_busy = ser_busy;

   // Walk downward so the candidate closest to rr_ptr is written last and wins.
   always_comb begin
      w_win = r_rr_ptr;
      w_idx = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         w_idx = {1'b0, r_rr_ptr} + (GW+1)'(k);
         if (w_idx >= (GW+1)'(N_REQ)) begin
            w_idx = w_idx - (GW+1)'(N_REQ);
         end
         if (req_valid[w_idx[GW-1:0]]) begin
            w_win = w_idx[GW-1:0];
         end
      end
   end

   assign w_after_grant = (grant_id == GW'(N_REQ - 1)) ? '0 : grant_id + GW'(1);

   always_comb begin
      w_state_nx     = r_state;
      w_rr_nx        = r_rr_ptr;
      w_timer_nx     = r_timer;
      w_ready_nx     = '0;
      w_ser_en_nx    = 1'b0;
      w_ser_data_nx  = ser_data;
      w_grant_nx     = grant_id;
      w_active_nx    = 1'b0;
      w_timeout_nx   = 1'b0;
      w_frame_cnt_nx = frame_cnt;
      unique case (r_state)
         IDLE: begin
            if (|req_valid) begin
               w_ser_data_nx     = req_data[{w_win, 3'b000} +: 8];
               w_grant_nx        = w_win;
               w_ready_nx[w_win] = 1'b1;
               w_ser_en_nx       = 1'b1;
               w_active_nx       = 1'b1;
               w_state_nx        = LAUNCH;
            end
         end
         LAUNCH: begin
            w_timer_nx  = '0;
            w_active_nx = 1'b1;
            w_state_nx  = WAIT_DONE;
         end
         WAIT_DONE: begin
            w_timer_nx  = r_timer + TW'(1);
            w_active_nx = 1'b1;
            // A done on the last allowed cycle still counts as a good frame.
            if (ser_done) begin
               w_frame_cnt_nx = frame_cnt + 16'd1;
               w_rr_nx        = w_after_grant;
               w_active_nx    = 1'b0;
               w_state_nx     = GAP;
            end else if (r_timer == TW'(TIMEOUT - 1)) begin
               w_timeout_nx   = 1'b1;
               w_rr_nx        = w_after_grant;
               w_active_nx    = 1'b0;
               w_state_nx     = GAP;
            end
         end
         GAP: begin
            w_state_nx = IDLE;
         end
         default: begin
            w_state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge baud_clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_rr_ptr    <= '0;
         r_timer     <= '0;
         req_ready   <= '0;
         ser_en      <= 1'b0;
         ser_data    <= 8'h00;
         grant_id    <= '0;
         active      <= 1'b0;
         timeout_err <= 1'b0;
         frame_cnt   <= 16'h0000;
      end else begin
         r_state     <= w_state_nx;
         r_rr_ptr    <= w_rr_nx;
         r_timer     <= w_timer_nx;
         req_ready   <= w_ready_nx;
         ser_en      <= w_ser_en_nx;
         ser_data    <= w_ser_data_nx;
         grant_id    <= w_grant_nx;
         active      <= w_active_nx;
         timeout_err <= w_timeout_nx;
         frame_cnt   <= w_frame_cnt_nx;
      end
   end

endmodule

`default_nettype wire
